// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: active-low glyphs, BCD decode and the scan slot type.
package seg7_pkg;

  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_DASH  = 8'hBF;

  typedef enum logic [1:0] {
    S0 = 2'd0,
    S1 = 2'd1,
    S2 = 2'd2,
    S3 = 2'd3
  } slot_t;

  // Non-decimal codes show a lone dash so a corrupted counter is visible.
  function automatic logic [7:0] bcd_to_seg(input logic [3:0] d);
    case (d)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_DASH;
    endcase
  endfunction

endpackage

// File: rtl/bcd2_counter.sv
// Two-digit BCD win counter: clear beats increment, saturates at 99.
module bcd2_counter (
  input  logic       clk,
  input  logic       clr_n,
  input  logic       clr,
  input  logic       inc,
  output logic [7:0] q
);

  logic [7:0] r_q;
  logic [7:0] w_q_nx;

  always_comb begin
    w_q_nx = r_q;
    if (clr) begin
      w_q_nx = 8'h00;
    end else if (inc && (r_q != 8'h99)) begin
      if (r_q[3:0] >= 4'd9) begin
        w_q_nx = {r_q[7:4] + 4'd1, 4'd0};
      end else begin
        w_q_nx = {r_q[7:4], r_q[3:0] + 4'd1};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      r_q <= 8'h00;
    end else begin
      r_q <= w_q_nx;
    end
  end

  assign q = r_q;

endmodule

// File: rtl/score_seg7_driver.sv
// Two-player BCD scoreboard driving a four-digit multiplexed seven-segment display
// with a blanking guard at the start of every digit slot.
module score_seg7_driver
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV = 25000,
  parameter int GUARD       = 64,
  parameter bit BLANK_LZ    = 1'b1
) (
  input  logic       clk,
  input  logic       clr_n,
  input  logic       p1_win,
  input  logic       p2_win,
  input  logic       score_clr,
  output logic [7:0] seg,
  output logic [3:0] an,
  output logic [7:0] p1_score,
  output logic [7:0] p2_score
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] P_LAST  = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] P_GUARD = PW'(GUARD);

  logic [PW-1:0] r_presc;
  logic [PW-1:0] w_presc_nx;
  slot_t         r_slot;
  slot_t         w_slot_nx;
  logic [3:0]    r_digit;
  logic [3:0]    w_digit_nx;
  logic          w_tens_nx;
  logic          w_wrap;
  logic          w_p1_inc;
  logic          w_p2_inc;
  logic [3:0]    r_an;
  logic [7:0]    r_seg;
  logic [3:0]    w_an_nx;
  logic [7:0]    w_seg_nx;

  // Simultaneous wins are treated as a glitch and both are dropped.
  assign w_p1_inc = p1_win & ~p2_win;
  assign w_p2_inc = p2_win & ~p1_win;

  bcd2_counter u_p1_cnt (
    .clk   (clk),
    .clr_n (clr_n),
    .clr   (score_clr),
    .inc   (w_p1_inc),
    .q     (p1_score)
  );

  bcd2_counter u_p2_cnt (
    .clk   (clk),
    .clr_n (clr_n),
    .clr   (score_clr),
    .inc   (w_p2_inc),
    .q     (p2_score)
  );

  assign w_wrap     = (r_presc == P_LAST);
  assign w_presc_nx = w_wrap ? '0 : r_presc + 1'b1;

  always_comb begin
    w_slot_nx = r_slot;
    if (w_wrap) begin
      case (r_slot)
        S0:      w_slot_nx = S1;
        S1:      w_slot_nx = S2;
        S2:      w_slot_nx = S3;
        default: w_slot_nx = S0;
      endcase
    end
  end

  // The digit is latched only at the slot boundary so a mid-slot win cannot alter the glyph.
  always_comb begin
    w_digit_nx = r_digit;
    if (w_wrap) begin
      case (w_slot_nx)
        S0:      w_digit_nx = p2_score[3:0];
        S1:      w_digit_nx = p2_score[7:4];
        S2:      w_digit_nx = p1_score[3:0];
        default: w_digit_nx = p1_score[7:4];
      endcase
    end
  end

  assign w_tens_nx = (w_slot_nx == S1) || (w_slot_nx == S3);

  // Outputs are computed from next-state values so the pins line up with the prescaler count.
  always_comb begin
    w_an_nx  = 4'hF;
    w_seg_nx = SEG_BLANK;
    if (w_presc_nx >= P_GUARD) begin
      w_an_nx = ~(4'b0001 << w_slot_nx);
      if (BLANK_LZ && w_tens_nx && (w_digit_nx == 4'd0)) begin
        w_seg_nx = SEG_BLANK;
      end else begin
        w_seg_nx = bcd_to_seg(w_digit_nx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      r_presc <= '0;
      r_slot  <= S0;
    end else begin
      r_presc <= w_presc_nx;
      r_slot  <= w_slot_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      r_digit <= 4'd0;
      r_an    <= 4'hF;
      r_seg   <= SEG_BLANK;
    end else begin
      r_digit <= w_digit_nx;
      r_an    <= w_an_nx;
      r_seg   <= w_seg_nx;
    end
  end

  assign an  = r_an;
  assign seg = r_seg;

endmodule

// File: tb/tb_score_seg7_driver.sv
// Bench for score_seg7_driver: directed scenarios plus random pulses, every cycle
// compared against an integer score model and a position-in-scan model.
module tb_score_seg7_driver;

  localparam int DIV = 8;
  localparam int GRD = 2;

  logic       clk;
  logic       clr_n;
  logic       p1_win;
  logic       p2_win;
  logic       score_clr;
  logic [7:0] seg;
  logic [3:0] an;
  logic [7:0] p1_score;
  logic [7:0] p2_score;

  score_seg7_driver #(
    .REFRESH_DIV (DIV),
    .GUARD       (GRD),
    .BLANK_LZ    (1'b1)
  ) dut (
    .clk       (clk),
    .clr_n     (clr_n),
    .p1_win    (p1_win),
    .p2_win    (p2_win),
    .score_clr (score_clr),
    .seg       (seg),
    .an        (an),
    .p1_score  (p1_score),
    .p2_score  (p2_score)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk  = 0;
  int n_pass = 0;

  // Model state: scores as integers, snapshot taken at each slot boundary, edges since reset.
  int m_p1 = 0, m_p2 = 0;
  int s_p1 = 0, s_p2 = 0;
  int k    = 0;

  logic [7:0] glyph [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                             8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (k=%0d)", tag, got, exp, k);
  endtask

  function automatic logic [7:0] to_bcd(input int v);
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction

  task automatic verify();
    int pr, sl, d;
    bit tens;
    logic [3:0] e_an;
    logic [7:0] e_seg;
    pr = k % DIV;
    sl = (k / DIV) % 4;
    case (sl)
      0:       d = s_p2 % 10;
      1:       d = s_p2 / 10;
      2:       d = s_p1 % 10;
      default: d = s_p1 / 10;
    endcase
    tens = (sl == 1) || (sl == 3);
    if (pr < GRD) begin
      e_an  = 4'hF;
      e_seg = 8'hFF;
    end else begin
      e_an  = ~(4'(1) << sl);
      e_seg = (tens && d == 0) ? 8'hFF : glyph[d];
    end
    check_eq("an", {28'd0, an}, {28'd0, e_an});
    check_eq("seg", {24'd0, seg}, {24'd0, e_seg});
    check_eq("p1_score", {24'd0, p1_score}, {24'd0, to_bcd(m_p1)});
    check_eq("p2_score", {24'd0, p2_score}, {24'd0, to_bcd(m_p2)});
    if (pr >= GRD) check_eq("one_anode", $countones(~an), 1);
  endtask

  task automatic step(input bit w1, input bit w2, input bit cl, input bit rn);
    p1_win    = w1;
    p2_win    = w2;
    score_clr = cl;
    clr_n     = rn;
    @(posedge clk);
    if (!rn) begin
      m_p1 = 0; m_p2 = 0; s_p1 = 0; s_p2 = 0; k = 0;
    end else begin
      if (k % DIV == DIV - 1) begin
        s_p1 = m_p1;
        s_p2 = m_p2;
      end
      if (cl) begin
        m_p1 = 0;
        m_p2 = 0;
      end else if (!(w1 && w2)) begin
        if (w1) m_p1 = (m_p1 < 99) ? m_p1 + 1 : 99;
        if (w2) m_p2 = (m_p2 < 99) ? m_p2 + 1 : 99;
      end
      k++;
    end
    @(negedge clk);
    verify();
    p1_win    = 1'b0;
    p2_win    = 1'b0;
    score_clr = 1'b0;
  endtask

  task automatic run_to(input int sl, input int pr, input string tag);
    int n;
    n = 0;
    while (!(((k / DIV) % 4 == sl) && (k % DIV == pr)) && n < 64) begin
      step(0, 0, 0, 1);
      n++;
    end
    if (n >= 64) begin
      n_chk++;
      $display("FAIL %s: scan position slot %0d count %0d not reached", tag, sl, pr);
    end
  endtask

  initial begin
    clr_n = 1'b0; p1_win = 1'b0; p2_win = 1'b0; score_clr = 1'b0;
    @(negedge clk);

    // Reset held three cycles, then the first active slot
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
    check_eq("rst_an", {28'd0, an}, 32'hF);
    check_eq("rst_seg", {24'd0, seg}, 32'hFF);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    check_eq("first_an", {28'd0, an}, 32'hE);
    check_eq("first_seg", {24'd0, seg}, 32'hC0);

    // Three player-1 wins, then slot 2 and blanked slot 3
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 1);
      for (int j = 0; j < 3; j++) step(0, 0, 0, 1);
    end
    check_eq("p1_3", {24'd0, p1_score}, 32'h03);
    check_eq("p2_0", {24'd0, p2_score}, 32'h00);
    run_to(2, 3, "reach_s2");
    check_eq("s2_an", {28'd0, an}, 32'hB);
    check_eq("s2_seg", {24'd0, seg}, 32'hB0);
    run_to(3, 3, "reach_s3");
    check_eq("s3_an", {28'd0, an}, 32'h7);
    check_eq("s3_seg", {24'd0, seg}, 32'hFF);

    // Dual win ignored, clear beats win
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 0, 1);
      step(0, 0, 0, 1);
    end
    step(1, 1, 0, 1);
    check_eq("dual_p1", {24'd0, p1_score}, 32'h03);
    check_eq("dual_p2", {24'd0, p2_score}, 32'h05);
    step(1, 0, 1, 1);
    check_eq("clr_p1", {24'd0, p1_score}, 32'h00);
    check_eq("clr_p2", {24'd0, p2_score}, 32'h00);

    // 100 player-2 wins: carry at 10, saturation at 99
    for (int i = 1; i <= 100; i++) begin
      step(0, 1, 0, 1);
      if (i == 9)  check_eq("p2_09", {24'd0, p2_score}, 32'h09);
      if (i == 10) check_eq("p2_10", {24'd0, p2_score}, 32'h10);
      step(0, 0, 0, 1);
    end
    check_eq("p2_sat", {24'd0, p2_score}, 32'h99);
    for (int i = 0; i < 32; i++) step(0, 0, 0, 1);
    run_to(1, GRD, "reach_s1");
    check_eq("s1_seg", {24'd0, seg}, 32'h90);

    // Random pulses, occasional clear and reset
    for (int i = 0; i < 1500; i++) begin
      int r;
      r = int'($urandom_range(0, 199));
      step(r < 30, (r >= 24) && (r < 60), r == 199, r != 198);
    end

    // Reset dropped mid slot 2
    run_to(2, 4, "reach_mid");
    step(0, 0, 0, 0);
    check_eq("mid_rst_an", {28'd0, an}, 32'hF);
    check_eq("mid_rst_p1", {24'd0, p1_score}, 32'h00);
    check_eq("mid_rst_p2", {24'd0, p2_score}, 32'h00);
    run_to(0, GRD, "reach_restart");
    check_eq("restart_an", {28'd0, an}, 32'hE);
    check_eq("restart_seg", {24'd0, seg}, 32'hC0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
